// File: rtl/axis_row_consumer_pkg.sv
// axis_consumer_pkg: state encoding and counter width helper shared by the row consumer
package axis_consumer_pkg;

    typedef enum logic {ST_IDLE, ST_RECEIVING} state_t;

    // Bits needed to hold the values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_row_consumer_if.sv
// axis_row_consumer_if: AXI-Stream bus bundle
//   AXIS_TDATA  - stream data
//   AXIS_TVALID - source valid
//   AXIS_TLAST  - source end-of-row marker
//   AXIS_TREADY - sink ready
interface axis_row_consumer_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] AXIS_TDATA;
    logic                  AXIS_TVALID;
    logic                  AXIS_TLAST;
    logic                  AXIS_TREADY;

    modport master (output AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, input AXIS_TREADY);
    modport slave  (input AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, output AXIS_TREADY);
endinterface

// File: rtl/axis_row_consumer_idle_timer.sv
// idle_timer: down-counter that flags source idleness during a partial row
//   clk, resetn - clock, synchronous active-low reset
//   reload      - restart the count at IDLE_TIMEOUT
//   enable      - count down one step this cycle
//   expired     - the enabled step reaches zero this cycle
module idle_timer
    import axis_consumer_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 400000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic reload,
    input  logic enable,
    output logic expired
);
    localparam int TW = cnt_width(IDLE_TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || reload)
            cnt <= TW'(IDLE_TIMEOUT);
        else if (enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // A reload in the same cycle always beats expiry
    assign expired = enable && !reload && cnt == TW'(1);

endmodule

// File: rtl/axis_row_consumer.sv
// axis_row_consumer: AXI-Stream sink that frames beats into rows and monitors row/error rates
//   clk, resetn    - clock, synchronous active-low reset
//   axis           - AXI-Stream slave (TDATA is not stored)
//   pause          - receiver backpressure, drops TREADY one cycle later
//   row_complete   - strobe per completed row
//   partial_row    - strobe when a partial row is dropped on idle timeout
//   framing_error  - strobe on a TLAST mismatch
//   beat_count     - beats accepted in the current row
//   row_count      - completed rows, wrapping
//   error_count    - framing errors plus partial rows, saturating
module axis_row_consumer
    import axis_consumer_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int BEATS_PER_ROW = 66,
    parameter int IDLE_TIMEOUT  = 400000000,
    parameter bit CHECK_TLAST   = 1'b1,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    axis_row_consumer_if.slave                    axis,
    input  logic                                  pause,
    output logic                                  row_complete,
    output logic                                  partial_row,
    output logic                                  framing_error,
    output logic [cnt_width(BEATS_PER_ROW)-1:0]   beat_count,
    output logic [COUNT_WIDTH-1:0]                row_count,
    output logic [COUNT_WIDTH-1:0]                error_count
);
    localparam int BW = cnt_width(BEATS_PER_ROW);

    state_t          state, state_nxt;
    logic            tready, hs, last_beat, early_last, late_miss, expired;
    logic            rc_nxt, pr_nxt, fe_nxt;
    logic [BW-1:0]   beat_nxt;

    assign axis.AXIS_TREADY = tready;
    assign hs         = axis.AXIS_TVALID && tready;
    assign last_beat  = beat_count == BW'(BEATS_PER_ROW - 1);
    assign early_last = CHECK_TLAST && axis.AXIS_TLAST && !last_beat;
    assign late_miss  = CHECK_TLAST && !axis.AXIS_TLAST && last_beat;

    // Stalls from our own pause are not source idleness, so the timer only runs while ready
    idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .reload  (hs),
        .enable  (state == ST_RECEIVING && tready && !hs),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (hs)
            state_nxt = (last_beat || early_last) ? ST_IDLE : ST_RECEIVING;
        else if (expired)
            state_nxt = ST_IDLE;
    end

    always_comb begin
        rc_nxt   = hs && last_beat;
        fe_nxt   = hs && (early_last || late_miss);
        pr_nxt   = expired;
        beat_nxt = beat_count;
        if (hs)
            beat_nxt = (last_beat || early_last) ? '0 : beat_count + 1'b1;
        else if (expired)
            beat_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tready        <= 1'b0;
            row_complete  <= 1'b0;
            partial_row   <= 1'b0;
            framing_error <= 1'b0;
            beat_count    <= '0;
            row_count     <= '0;
            error_count   <= '0;
        end else begin
            tready        <= !pause;
            row_complete  <= rc_nxt;
            partial_row   <= pr_nxt;
            framing_error <= fe_nxt;
            beat_count    <= beat_nxt;
            row_count     <= row_count + COUNT_WIDTH'(rc_nxt);
            if ((fe_nxt || pr_nxt) && !(&error_count))
                error_count <= error_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_row_consumer.sv
// tb_axis_row_consumer: directed self-checking bench for axis_row_consumer
module tb_axis_row_consumer;
    localparam int BPR = 4;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pause = 1'b0;
    logic        row_complete, partial_row, framing_error;
    logic [2:0]  beat_count;
    logic [31:0] row_count, error_count;
    int          passed = 0, total = 0;
    int          rc_cnt = 0, fe_cnt = 0, pr_cnt = 0;

    axis_row_consumer_if #(.DATA_WIDTH(8)) s ();

    axis_row_consumer #(
        .DATA_WIDTH(8), .BEATS_PER_ROW(BPR), .IDLE_TIMEOUT(TO),
        .CHECK_TLAST(1'b1), .COUNT_WIDTH(32)
    ) dut (
        .clk(clk), .resetn(resetn), .axis(s), .pause(pause),
        .row_complete(row_complete), .partial_row(partial_row),
        .framing_error(framing_error), .beat_count(beat_count),
        .row_count(row_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rc_cnt <= rc_cnt + int'(row_complete);
        fe_cnt <= fe_cnt + int'(framing_error);
        pr_cnt <= pr_cnt + int'(partial_row);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic last);
        s.AXIS_TVALID = 1'b1;
        s.AXIS_TLAST  = last;
        s.AXIS_TDATA  = 8'($urandom);
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        total++; if (s.AXIS_TREADY !== 1'b0) $display("FAIL reset_tready got %b want 0", s.AXIS_TREADY); else passed++;
        total++; if ({row_complete, partial_row, framing_error} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {row_complete, partial_row, framing_error}); else passed++;
        total++; if (beat_count !== 3'd0) $display("FAIL reset_beat got %0d want 0", beat_count); else passed++;
        total++; if (row_count !== 32'd0 || error_count !== 32'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", row_count, error_count); else passed++;
        resetn = 1'b1;
        tick();
        total++; if (s.AXIS_TREADY !== 1'b1) $display("FAIL release_tready got %b want 1", s.AXIS_TREADY); else passed++;
    endtask

    task automatic test_rows();
        int rc0 = rc_cnt;
        for (int i = 1; i <= 12; i++) begin
            beat(i % 4 == 0);
            total++; if (beat_count !== 3'(i % 4)) $display("FAIL rows_beat%0d got %0d want %0d", i, beat_count, i % 4); else passed++;
            total++; if (row_complete !== (i % 4 == 0)) $display("FAIL rows_strobe%0d got %b want %b", i, row_complete, i % 4 == 0); else passed++;
        end
        s.AXIS_TVALID = 1'b0;
        tick();
        total++; if (rc_cnt - rc0 !== 3) $display("FAIL rows_strobes got %0d want 3", rc_cnt - rc0); else passed++;
        total++; if (row_count !== 32'd3 || error_count !== 32'd0) $display("FAIL rows_counts got %0d/%0d want 3/0", row_count, error_count); else passed++;
    endtask

    task automatic test_framing();
        beat(1'b0);
        beat(1'b1);
        total++; if (framing_error !== 1'b1 || row_complete !== 1'b0) $display("FAIL early_last_strobes got fe=%b rc=%b want fe=1 rc=0", framing_error, row_complete); else passed++;
        total++; if (beat_count !== 3'd0) $display("FAIL early_last_beat got %0d want 0", beat_count); else passed++;
        total++; if (row_count !== 32'd3 || error_count !== 32'd1) $display("FAIL early_last_counts got %0d/%0d want 3/1", row_count, error_count); else passed++;
        for (int i = 1; i <= 4; i++) beat(i == 4);
        total++; if (row_count !== 32'd4 || error_count !== 32'd1) $display("FAIL recover_counts got %0d/%0d want 4/1", row_count, error_count); else passed++;
        for (int i = 1; i <= 4; i++) beat(1'b0);
        total++; if (row_complete !== 1'b1 || framing_error !== 1'b1) $display("FAIL missing_last_strobes got rc=%b fe=%b want 1/1", row_complete, framing_error); else passed++;
        total++; if (row_count !== 32'd5 || error_count !== 32'd2) $display("FAIL missing_last_counts got %0d/%0d want 5/2", row_count, error_count); else passed++;
        s.AXIS_TVALID = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        for (int i = 0; i < 3; i++) beat(1'b0);
        s.AXIS_TVALID = 1'b0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick();
            if (partial_row) n = i;
        end
        total++; if (n !== TO) $display("FAIL timeout_latency got %0d want %0d", n, TO); else passed++;
        total++; if (beat_count !== 3'd0 || error_count !== 32'd3) $display("FAIL timeout_state got beat=%0d err=%0d want 0/3", beat_count, error_count); else passed++;
        tick();
        total++; if (partial_row !== 1'b0) $display("FAIL timeout_one_shot got %b want 0", partial_row); else passed++;
    endtask

    task automatic test_pause();
        int pr0 = pr_cnt;
        beat(1'b0);
        beat(1'b0);
        pause = 1'b1;
        beat(1'b0);
        s.AXIS_TVALID = 1'b0;
        total++; if (beat_count !== 3'd3 || s.AXIS_TREADY !== 1'b0) $display("FAIL pause_accept got beat=%0d tready=%b want 3/0", beat_count, s.AXIS_TREADY); else passed++;
        repeat (50) tick();
        pause = 1'b0;
        tick();
        total++; if (s.AXIS_TREADY !== 1'b1) $display("FAIL pause_release got %b want 1", s.AXIS_TREADY); else passed++;
        total++; if (pr_cnt - pr0 !== 0 || beat_count !== 3'd3) $display("FAIL pause_no_timeout got pr=%0d beat=%0d want 0/3", pr_cnt - pr0, beat_count); else passed++;
        beat(1'b1);
        s.AXIS_TVALID = 1'b0;
        total++; if (row_complete !== 1'b1 || row_count !== 32'd6) $display("FAIL pause_complete got rc=%b rows=%0d want 1/6", row_complete, row_count); else passed++;
        tick();
    endtask

    task automatic test_expire_handshake();
        int pr0 = pr_cnt;
        beat(1'b0);
        beat(1'b0);
        s.AXIS_TVALID = 1'b0;
        repeat (TO - 1) tick();
        beat(1'b0);
        s.AXIS_TVALID = 1'b0;
        total++; if (partial_row !== 1'b0 || beat_count !== 3'd3) $display("FAIL expire_hs got pr=%b beat=%0d want 0/3", partial_row, beat_count); else passed++;
        repeat (TO - 1) tick();
        beat(1'b1);
        s.AXIS_TVALID = 1'b0;
        total++; if (pr_cnt - pr0 !== 0 || row_count !== 32'd7 || error_count !== 32'd3) $display("FAIL expire_hs_row got pr=%0d rows=%0d err=%0d want 0/7/3", pr_cnt - pr0, row_count, error_count); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_row();
        int pr0 = pr_cnt;
        beat(1'b0);
        beat(1'b0);
        s.AXIS_TVALID = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        total++; if (s.AXIS_TREADY !== 1'b0 || beat_count !== 3'd0) $display("FAIL midreset_state got tready=%b beat=%0d want 0/0", s.AXIS_TREADY, beat_count); else passed++;
        total++; if (row_count !== 32'd0 || error_count !== 32'd0) $display("FAIL midreset_counts got %0d/%0d want 0/0", row_count, error_count); else passed++;
        tick();
        total++; if (s.AXIS_TREADY !== 1'b1) $display("FAIL midreset_tready got %b want 1", s.AXIS_TREADY); else passed++;
        repeat (2 * TO) tick();
        total++; if (pr_cnt - pr0 !== 0 || error_count !== 32'd0) $display("FAIL midreset_silent got pr=%0d err=%0d want 0/0", pr_cnt - pr0, error_count); else passed++;
    endtask

    initial begin
        s.AXIS_TVALID = 1'b0;
        s.AXIS_TLAST  = 1'b0;
        s.AXIS_TDATA  = '0;
        test_reset();
        test_rows();
        test_framing();
        test_timeout();
        test_pause();
        test_expire_handshake();
        test_reset_mid_row();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
